// File: rtl/uart_packet_decoder.sv
// rtl/uart_packet_decoder.sv - decodes UART position packets into per-player outputs
// Defining UART_DEC_STATS_EN adds saturating pkt_ok_cnt / pkt_err_cnt outputs.
module uart_packet_decoder #(
   parameter int NUM_PLAYERS = 2,
   parameter int COORD_W     = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [7:0]                     read_data,
   input  logic                           rx_empty,
   output logic                           rd_uart,
   output logic [NUM_PLAYERS*COORD_W-1:0] pos_x,
   output logic [NUM_PLAYERS*COORD_W-1:0] pos_y,
   output logic [NUM_PLAYERS-1:0]         collision,
   output logic                           upd_valid,
   output logic [3:0]                     upd_player,
   output logic                           frame_err
`ifdef UART_DEC_STATS_EN
   ,
   output logic [15:0]                    pkt_ok_cnt,
   output logic [15:0]                    pkt_err_cnt
`endif
);

   localparam int NB = COORD_W / 8;
   localparam int PW = NUM_PLAYERS * COORD_W;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [1:0]    LAST_B   = 2'(NB - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {IDLE, X, Y, FLAGS, CSUM} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             byte_cnt_q, byte_cnt_d;
   logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
   logic [3:0]             idx_q, idx_d;
   logic [COORD_W-1:0]     x_sh_q, x_sh_d, y_sh_q, y_sh_d;
   logic                   col_sh_q, col_sh_d;
   logic [7:0]             csum_q, csum_d;
   logic                   rd_uart_q, rd_uart_d;
   logic [PW-1:0]          pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [NUM_PLAYERS-1:0] coll_q, coll_d;
   logic                   upd_valid_q, upd_valid_d;
   logic [3:0]             upd_player_q, upd_player_d;
   logic                   frame_err_q, frame_err_d;
   logic                   take;
   logic                   clear_sh;

   always_comb begin
      take         = !rx_empty && !rd_uart_q;
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      idx_d        = idx_q;
      x_sh_d       = x_sh_q;
      y_sh_d       = y_sh_q;
      col_sh_d     = col_sh_q;
      csum_d       = csum_q;
      pos_x_d      = pos_x_q;
      pos_y_d      = pos_y_q;
      coll_d       = coll_q;
      upd_player_d = upd_player_q;
      rd_uart_d    = take;
      upd_valid_d  = 1'b0;
      frame_err_d  = 1'b0;
      clear_sh     = 1'b0;

      if (state_q == IDLE || take) begin
         tmo_cnt_d = '0;
      end else if (tmo_cnt_q >= TMO_LAST) begin
         tmo_cnt_d   = '0;
         frame_err_d = 1'b1;
         state_d     = IDLE;
         clear_sh    = 1'b1;
      end else begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end

      if (take) begin
         csum_d = csum_q ^ read_data;
         case (state_q)
            IDLE: begin
               // only a header byte starts a packet; the accumulator restarts from it
               if (read_data[7:4] == 4'hA) begin
                  idx_d      = read_data[3:0];
                  csum_d     = read_data;
                  byte_cnt_d = '0;
                  state_d    = X;
               end else begin
                  csum_d = '0;
               end
            end
            X: begin
               x_sh_d = COORD_W'({x_sh_q, read_data});
               if (byte_cnt_q == LAST_B) begin
                  byte_cnt_d = '0;
                  state_d    = Y;
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
            Y: begin
               y_sh_d = COORD_W'({y_sh_q, read_data});
               if (byte_cnt_q == LAST_B) begin
                  byte_cnt_d = '0;
                  state_d    = FLAGS;
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
            FLAGS: begin
               col_sh_d = read_data[0];
               state_d  = CSUM;
            end
            CSUM: begin
               state_d  = IDLE;
               clear_sh = 1'b1;
               if (read_data == csum_q && idx_q < 4'(NUM_PLAYERS)) begin
                  for (int p = 0; p < NUM_PLAYERS; p++) begin
                     if (idx_q == 4'(p)) begin
                        pos_x_d[p*COORD_W +: COORD_W] = x_sh_q;
                        pos_y_d[p*COORD_W +: COORD_W] = y_sh_q;
                        coll_d[p]                     = col_sh_q;
                     end
                  end
                  upd_player_d = idx_q;
                  upd_valid_d  = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (clear_sh) begin
         idx_d      = '0;
         x_sh_d     = '0;
         y_sh_d     = '0;
         col_sh_d   = 1'b0;
         csum_d     = '0;
         byte_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         byte_cnt_q   <= '0;
         tmo_cnt_q    <= '0;
         idx_q        <= '0;
         x_sh_q       <= '0;
         y_sh_q       <= '0;
         col_sh_q     <= 1'b0;
         csum_q       <= '0;
         rd_uart_q    <= 1'b0;
         pos_x_q      <= '0;
         pos_y_q      <= '0;
         coll_q       <= '0;
         upd_valid_q  <= 1'b0;
         upd_player_q <= '0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         idx_q        <= idx_d;
         x_sh_q       <= x_sh_d;
         y_sh_q       <= y_sh_d;
         col_sh_q     <= col_sh_d;
         csum_q       <= csum_d;
         rd_uart_q    <= rd_uart_d;
         pos_x_q      <= pos_x_d;
         pos_y_q      <= pos_y_d;
         coll_q       <= coll_d;
         upd_valid_q  <= upd_valid_d;
         upd_player_q <= upd_player_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign rd_uart    = rd_uart_q;
   assign pos_x      = pos_x_q;
   assign pos_y      = pos_y_q;
   assign collision  = coll_q;
   assign upd_valid  = upd_valid_q;
   assign upd_player = upd_player_q;
   assign frame_err  = frame_err_q;

`ifdef UART_DEC_STATS_EN
   logic [15:0] pkt_ok_q, pkt_ok_d, pkt_err_q, pkt_err_d;

   always_comb begin
      pkt_ok_d  = pkt_ok_q;
      pkt_err_d = pkt_err_q;
      if (upd_valid_q && pkt_ok_q != 16'hFFFF)
         pkt_ok_d = pkt_ok_q + 16'd1;
      if (frame_err_q && pkt_err_q != 16'hFFFF)
         pkt_err_d = pkt_err_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_ok_q  <= '0;
         pkt_err_q <= '0;
      end else begin
         pkt_ok_q  <= pkt_ok_d;
         pkt_err_q <= pkt_err_d;
      end
   end

   assign pkt_ok_cnt  = pkt_ok_q;
   assign pkt_err_cnt = pkt_err_q;
`endif

endmodule

// File: tb/tb_uart_packet_decoder.sv
// tb/tb_uart_packet_decoder.sv - directed and random packet checks on 8- and 16-bit decoders
module tb_uart_packet_decoder;

   localparam int NP  = 2;
   localparam int TMO = 40;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [7:0]  rd_a, rd_b;
   logic        emp_a, emp_b, pop_a, pop_b;
   logic [15:0] px_a, py_a;
   logic [31:0] px_b, py_b;
   logic [1:0]  col_a, col_b;
   logic        uv_a, uv_b, fe_a, fe_b;
   logic [3:0]  up_a, up_b;
`ifdef UART_DEC_STATS_EN
   logic [15:0] okc_a, errc_a, okc_b, errc_b;
`endif

   uart_packet_decoder #(.NUM_PLAYERS(NP), .COORD_W(8), .TIMEOUT_CYC(TMO)) dut_a (
      .clk(clk), .rst(rst), .read_data(rd_a), .rx_empty(emp_a), .rd_uart(pop_a),
      .pos_x(px_a), .pos_y(py_a), .collision(col_a), .upd_valid(uv_a),
      .upd_player(up_a), .frame_err(fe_a)
`ifdef UART_DEC_STATS_EN
      , .pkt_ok_cnt(okc_a), .pkt_err_cnt(errc_a)
`endif
   );

   uart_packet_decoder #(.NUM_PLAYERS(NP), .COORD_W(16), .TIMEOUT_CYC(TMO)) dut_b (
      .clk(clk), .rst(rst), .read_data(rd_b), .rx_empty(emp_b), .rd_uart(pop_b),
      .pos_x(px_b), .pos_y(py_b), .collision(col_b), .upd_valid(uv_b),
      .upd_player(up_b), .frame_err(fe_b)
`ifdef UART_DEC_STATS_EN
      , .pkt_ok_cnt(okc_b), .pkt_err_cnt(errc_b)
`endif
   );

   logic [7:0] q_a[$];
   logic [7:0] q_b[$];

   // FIFO model: pop on the negedge inside the rd_uart cycle, present the new head after it
   always @(negedge clk) begin
      if (pop_a && q_a.size() > 0) void'(q_a.pop_front());
      if (pop_b && q_b.size() > 0) void'(q_b.pop_front());
      emp_a = (q_a.size() == 0);
      rd_a  = emp_a ? 8'h00 : q_a[0];
      emp_b = (q_b.size() == 0);
      rd_b  = emp_b ? 8'h00 : q_b[0];
   end

   int   ok_n[2], fe_n[2], viol;
   logic pop_a_prev = 1'b0, pop_b_prev = 1'b0;

   always @(negedge clk) begin
      if (uv_a) ok_n[0]++;
      if (fe_a) fe_n[0]++;
      if (uv_b) ok_n[1]++;
      if (fe_b) fe_n[1]++;
      if ((pop_a && pop_a_prev) || (pop_b && pop_b_prev)) viol++;
      if ((uv_a && fe_a) || (uv_b && fe_b)) viol++;
      pop_a_prev = pop_a;
      pop_b_prev = pop_b;
   end

   int n_chk = 0, n_err = 0;

   logic [15:0] ex_x[2][NP];
   logic [15:0] ex_y[2][NP];
   logic        ex_c[2][NP];
   logic [3:0]  ex_up[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q_a.size() : q_b.size();
   endfunction

   // Reference: walk the byte stream as packets and apply the acceptance rules
   task automatic model(input int d, input bq_t s, output int n_ok, output int n_bad);
      int          nb, i;
      logic [7:0]  sum;
      logic [15:0] x, y;
      logic [3:0]  idx;
      nb = (d == 0) ? 1 : 2;
      i = 0; n_ok = 0; n_bad = 0;
      while (i + 2*nb + 2 < s.size()) begin
         if (s[i][7:4] != 4'hA) begin
            i++;
         end else begin
            sum = 8'h00; x = 16'h0; y = 16'h0;
            for (int k = 0; k < 2*nb + 2; k++) sum ^= s[i+k];
            for (int k = 0; k < nb; k++) begin
               x = {x[7:0], s[i+1+k]};
               y = {y[7:0], s[i+1+nb+k]};
            end
            idx = s[i][3:0];
            if (sum == s[i+2*nb+2] && idx < NP) begin
               ex_x[d][idx] = x;
               ex_y[d][idx] = y;
               ex_c[d][idx] = s[i+2*nb+1][0];
               ex_up[d]     = idx;
               n_ok++;
            end else begin
               n_bad++;
            end
            i += 2*nb + 3;
         end
      end
   endtask

   function automatic bq_t mkpkt(input int d, input logic [3:0] idx, input logic [15:0] x,
                                 input logic [15:0] y, input logic [7:0] fl, input bit bad);
      bq_t        s;
      logic [7:0] c;
      s.push_back({4'hA, idx});
      if (d == 1) s.push_back(x[15:8]);
      s.push_back(x[7:0]);
      if (d == 1) s.push_back(y[15:8]);
      s.push_back(y[7:0]);
      s.push_back(fl);
      c = 8'h00;
      foreach (s[k]) c ^= s[k];
      s.push_back(bad ? ~c : c);
      return s;
   endfunction

   task automatic check_outputs(input int d, input string tag);
      for (int p = 0; p < NP; p++) begin
         if (d == 0) begin
            chk($sformatf("%s_x%0d", tag, p), {24'h0, px_a[p*8 +: 8]}, {16'h0, ex_x[0][p]});
            chk($sformatf("%s_y%0d", tag, p), {24'h0, py_a[p*8 +: 8]}, {16'h0, ex_y[0][p]});
            chk($sformatf("%s_c%0d", tag, p), {31'h0, col_a[p]}, {31'h0, ex_c[0][p]});
         end else begin
            chk($sformatf("%s_x%0d", tag, p), {16'h0, px_b[p*16 +: 16]}, {16'h0, ex_x[1][p]});
            chk($sformatf("%s_y%0d", tag, p), {16'h0, py_b[p*16 +: 16]}, {16'h0, ex_y[1][p]});
            chk($sformatf("%s_c%0d", tag, p), {31'h0, col_b[p]}, {31'h0, ex_c[1][p]});
         end
      end
      chk({tag, "_up"}, {28'h0, (d == 0) ? up_a : up_b}, {28'h0, ex_up[d]});
   endtask

   task automatic drain(input int d, input string tag);
      int n;
      n = 0;
      while (qsize(d) != 0 && n < 400) begin
         tick();
         n++;
      end
      chk({tag, "_drain"}, qsize(d), 0);
   endtask

   task automatic send(input int d, input bq_t s, input string tag);
      int eo, ee, ok0, fe0;
      model(d, s, eo, ee);
      ok0 = ok_n[d];
      fe0 = fe_n[d];
      foreach (s[k]) begin
         if (d == 0) q_a.push_back(s[k]);
         else        q_b.push_back(s[k]);
      end
      drain(d, tag);
      repeat (4) tick();
      chk({tag, "_nok"}, ok_n[d] - ok0, eo);
      chk({tag, "_nerr"}, fe_n[d] - fe0, ee);
      check_outputs(d, tag);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_a"}, {px_a, py_a}, 32'h0);
      chk({tag, "_a_misc"}, {23'h0, pop_a, col_a, uv_a, up_a, fe_a}, 32'h0);
      chk({tag, "_b_x"}, px_b, 32'h0);
      chk({tag, "_b_y"}, py_b, 32'h0);
      chk({tag, "_b_misc"}, {23'h0, pop_b, col_b, uv_b, up_b, fe_b}, 32'h0);
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++) begin
         ex_up[d] = 4'h0;
         for (int p = 0; p < NP; p++) begin
            ex_x[d][p] = 16'h0;
            ex_y[d][p] = 16'h0;
            ex_c[d][p] = 1'b0;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1);
   end

   initial begin
      bq_t        s, p;
      int         d, ok0, fe0, ok1, fe1;
      logic [7:0] g;

      rst = 1'b1;
      emp_a = 1'b1; emp_b = 1'b1; rd_a = 8'h00; rd_b = 8'h00;
      clear_model();
      repeat (3) tick();
      check_zero("reset");
`ifdef UART_DEC_STATS_EN
      chk("reset_cnt", {okc_a, errc_a}, 32'h0);
`endif
      rst = 1'b0;
      tick();

      s = '{8'hA1, 8'h3C, 8'h7F, 8'h01, 8'hE3};
      send(0, s, "basic");
      chk("basic_px1", {24'h0, px_a[15:8]}, 32'h3C);
      chk("basic_py1", {24'h0, py_a[15:8]}, 32'h7F);

      s = '{8'hA0, 8'h10, 8'h20, 8'h00, 8'h00};
      send(0, s, "badsum");

      s = '{8'h55, 8'hFF};
      p = mkpkt(0, 4'd0, 16'h5A, 16'hC3, 8'hFE, 1'b0);
      foreach (p[k]) s.push_back(p[k]);
      send(0, s, "garbage");

      s = mkpkt(0, 4'd0, 16'hA5, 16'hAA, 8'hA1, 1'b0);
      send(0, s, "adata");

      ok0 = ok_n[0];
      fe0 = fe_n[0];
      q_a.push_back(8'hA1); q_a.push_back(8'h11); q_a.push_back(8'h22);
      drain(0, "tmo");
      repeat (TMO - 6) tick();
      chk("tmo_early", fe_n[0] - fe0, 0);
      repeat (12) tick();
      chk("tmo_err", fe_n[0] - fe0, 1);
      chk("tmo_nok", ok_n[0] - ok0, 0);
      check_outputs(0, "tmo");
      s = mkpkt(0, 4'd1, 16'h66, 16'h77, 8'h00, 1'b0);
      send(0, s, "post_tmo");

      s = mkpkt(0, 4'd5, 16'h99, 16'h88, 8'h01, 1'b0);
      send(0, s, "idx5_a");
      s = mkpkt(1, 4'd1, 16'h1234, 16'hBEEF, 8'h01, 1'b0);
      send(1, s, "w16");
      chk("w16_px1", {16'h0, px_b[31:16]}, 32'h1234);
      s = mkpkt(1, 4'd5, 16'h4321, 16'h0F0F, 8'h00, 1'b0);
      send(1, s, "idx5_b");

      for (int it = 0; it < 24; it++) begin
         d = int'($urandom_range(1, 0));
         s.delete();
         if ($urandom_range(3, 0) == 0) begin
            g = 8'($urandom);
            if (g[7:4] == 4'hA) g ^= 8'h10;
            s.push_back(g);
         end
         p = mkpkt(d, 4'($urandom_range(3, 0)), 16'($urandom), 16'($urandom),
                   8'($urandom), $urandom_range(3, 0) == 0);
         foreach (p[k]) s.push_back(p[k]);
         if ($urandom_range(1, 0) == 1) begin
            p = mkpkt(d, 4'($urandom_range(2, 0)), 16'($urandom), 16'($urandom),
                      8'($urandom), 1'b0);
            foreach (p[k]) s.push_back(p[k]);
         end
         send(d, s, $sformatf("rnd%0d", it));
      end

      q_a.push_back(8'hA1); q_a.push_back(8'h3C); q_a.push_back(8'h7F);
      q_b.push_back(8'hA0); q_b.push_back(8'h12); q_b.push_back(8'h34);
      q_b.push_back(8'h56); q_b.push_back(8'h78);
      drain(0, "mid_a");
      drain(1, "mid_b");
      tick();
      ok0 = ok_n[0]; fe0 = fe_n[0]; ok1 = ok_n[1]; fe1 = fe_n[1];
      rst = 1'b1;
      repeat (2) tick();
      check_zero("midrst");
      rst = 1'b0;
      repeat (3) tick();
      chk("midrst_pulses", (ok_n[0] - ok0) + (fe_n[0] - fe0) + (ok_n[1] - ok1) + (fe_n[1] - fe1), 0);
      clear_model();
      s = mkpkt(0, 4'd1, 16'h3C, 16'h7F, 8'h01, 1'b0);
      send(0, s, "postrst_a");
      s = mkpkt(1, 4'd0, 16'hCAFE, 16'h0102, 8'h00, 1'b0);
      send(1, s, "postrst_b");
`ifdef UART_DEC_STATS_EN
      chk("stats_a", {okc_a, errc_a}, {16'd1, 16'd0});
      chk("stats_b", {okc_b, errc_b}, {16'd1, 16'd0});
`endif

      chk("protocol_viol", viol, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_packet_decoder.md
UART_PACKET_DECODER -- requirements
Module: uart_packet_decoder

Interface
REQ-001 The block SHALL have parameter NUM_PLAYERS, default 2, meaning the number of player slots (range 1..15).
REQ-002 The block SHALL have parameter COORD_W, default 8, meaning the coordinate width in bits (8 or 16 only).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 100000, meaning the maximum clock count allowed between bytes of one packet.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-006 The block SHALL have port read_data, input, 8 bits: the RX FIFO head byte.
REQ-007 The block SHALL have port rx_empty, input, 1 bit: the RX FIFO empty flag.
REQ-008 The block SHALL have port rd_uart, output, 1 bit: the FIFO pop strobe.
REQ-009 The block SHALL have port pos_x, output, NUM_PLAYERS*COORD_W bits: the X positions, with player p at slice [p*COORD_W +: COORD_W].
REQ-010 The block SHALL have port pos_y, output, NUM_PLAYERS*COORD_W bits: the Y positions, packed the same way as pos_x.
REQ-011 The block SHALL have port collision, output, NUM_PLAYERS bits: the per-player collision flags.
REQ-012 The block SHALL have port upd_valid, output, 1 bit: a one-cycle pulse on each packet commit.
REQ-013 The block SHALL have port upd_player, output, 4 bits: the player index of the last commit.
REQ-014 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a checksum, index or timeout failure.

Function
REQ-015 Packet format SHALL be:
- header: [7:4]=4'hA, [3:0]=player index;
- X: COORD_W/8 bytes, MSB first;
- Y: COORD_W/8 bytes, MSB first;
- flags: bit0 = collision, bits [7:1] ignored;
- checksum: XOR of all preceding bytes of the packet.
REQ-016 The block SHALL consume a byte in a cycle when rx_empty=0 and rd_uart=0, and SHALL assert rd_uart for exactly the following cycle; throughput is therefore at most one byte per 2 cycles.
REQ-017 The FSM SHALL have states IDLE, X, Y, FLAGS, CSUM.
- IDLE: a header byte moves to X; any other byte is discarded and the FSM stays in IDLE.
- X and Y: each advances after COORD_W/8 bytes, tracked by a byte counter.
- FLAGS: advances to CSUM after one byte.
- CSUM: returns to IDLE after one byte.
REQ-018 Received fields SHALL go to shadow registers only; player outputs SHALL change only at commit.
REQ-019 On the CSUM byte, if the checksum matches and the index is below NUM_PLAYERS, the block SHALL, in the cycle after consumption:
- update pos_x, pos_y and collision for that player atomically;
- set upd_player to the index;
- pulse upd_valid.
REQ-020 On a checksum mismatch, the block SHALL leave player outputs unchanged and pulse frame_err one cycle after the CSUM byte.
REQ-021 If the index is at least NUM_PLAYERS, the block SHALL still consume the whole packet, then pulse frame_err instead of committing.
REQ-022 A byte of 0xA? received in states X through CSUM SHALL be treated as data, not as a resync.
REQ-023 If TIMEOUT_CYC clocks elapse outside IDLE with no byte consumed, the block SHALL discard the shadow registers, return to IDLE and pulse frame_err once.
REQ-024 The timeout counter SHALL saturate, SHALL clear on every consumed byte, and SHALL be held at 0 in IDLE.
REQ-025 upd_valid and frame_err SHALL never be asserted in the same cycle.

Reset
REQ-026 While rst=1, the block SHALL hold the FSM in IDLE and SHALL drive all of the following to 0: rd_uart, pos_x, pos_y, collision, upd_valid, upd_player, frame_err, the counters and the shadow registers.
REQ-027 A reset asserted mid-packet SHALL discard the partial packet with no commit and no frame_err.

Configuration
REQ-028 When UART_DEC_STATS_EN is defined, the block SHALL add the following 16-bit outputs, each reset to 0, each saturating at 16'hFFFF:
- pkt_ok_cnt: counts upd_valid pulses;
- pkt_err_cnt: counts frame_err pulses.
REQ-029 When UART_DEC_STATS_EN is not defined, the block SHALL have neither those ports nor the counter logic, and its behaviour SHALL otherwise be identical.

Verification
REQ-030 Bench SHALL cover, with COORD_W=8 and FIFO bytes A1,3C,7F,01,E3: pos_x[15:8]=3C, pos_y[15:8]=7F, collision[1]=1, upd_player=1, one upd_valid pulse, and rd_uart never high on two consecutive cycles.
REQ-031 Bench SHALL cover bytes A0,10,20,00,00 (bad checksum): frame_err pulses once and all outputs are unchanged.
REQ-032 Bench SHALL cover garbage bytes 55,FF followed by a valid packet for player 0: the garbage is dropped and player 0 commits.
REQ-033 Bench SHALL cover A1 plus two bytes, then TIMEOUT_CYC idle cycles: frame_err at the timeout, no commit, and a following valid packet is accepted.
REQ-034 Bench SHALL cover a valid packet with index 5 when NUM_PLAYERS=2: frame_err, no output change; with COORD_W=16, X bytes 12,34 give 16'h1234.
REQ-035 Bench SHALL cover rst asserted after the Y byte of a packet: all outputs read 0, and the post-reset packet decodes correctly; with the macro defined, the counters read ok=1, err=0 after that packet.
